// File: rtl/plic_mc_if.sv
// Bundle of the PLIC register-write, IRQ, claim and complete signals.
// Edge-trigger configuration ports appear only when PLIC_MC_EDGE_TRIG_EN is defined.
interface plic_mc_if #(
  parameter int NSOURCES   = 16,
  parameter int NCONTEXTS  = 2,
  parameter int PRIO_WIDTH = 3,
  parameter int ID_WIDTH   = $clog2(NSOURCES+1)
);
  logic [NSOURCES-1:0]            src_i;
  logic                           prio_we_i;
  logic [NSOURCES*PRIO_WIDTH-1:0] prio_wdata_i;
  logic [NCONTEXTS-1:0]           en_we_i;
  logic [NSOURCES-1:0]            en_wdata_i;
  logic [NCONTEXTS-1:0]           thr_we_i;
  logic [PRIO_WIDTH-1:0]          thr_wdata_i;
  logic [NCONTEXTS-1:0]           claim_req_i;
  logic [NCONTEXTS-1:0]           complete_i;
  logic [NCONTEXTS*ID_WIDTH-1:0]  complete_id_i;
  logic [NCONTEXTS-1:0]           ext_irq_o;
  logic [NCONTEXTS-1:0]           claim_valid_o;
  logic [NCONTEXTS*ID_WIDTH-1:0]  claim_id_o;
`ifdef PLIC_MC_EDGE_TRIG_EN
  logic                           trig_we_i;
  logic [NSOURCES-1:0]            trig_wdata_i;
`endif

  modport slave (
`ifdef PLIC_MC_EDGE_TRIG_EN
    input  trig_we_i, trig_wdata_i,
`endif
    input  src_i, prio_we_i, prio_wdata_i, en_we_i, en_wdata_i, thr_we_i, thr_wdata_i,
    input  claim_req_i, complete_i, complete_id_i,
    output ext_irq_o, claim_valid_o, claim_id_o
  );

  modport master (
`ifdef PLIC_MC_EDGE_TRIG_EN
    output trig_we_i, trig_wdata_i,
`endif
    output src_i, prio_we_i, prio_wdata_i, en_we_i, en_wdata_i, thr_we_i, thr_wdata_i,
    output claim_req_i, complete_i, complete_id_i,
    input  ext_irq_o, claim_valid_o, claim_id_o
  );
endinterface

// File: rtl/plic_mc.sv
// Multi-context PLIC: per-source gateway, per-context enable/threshold arbitration, claim/complete.
// Define PLIC_MC_EDGE_TRIG_EN to add per-source rising-edge triggering (trig_we_i/trig_wdata_i).
module plic_mc #(
  parameter int NSOURCES   = 16,
  parameter int NCONTEXTS  = 2,
  parameter int PRIO_WIDTH = 3,
  parameter int ID_WIDTH   = $clog2(NSOURCES+1)
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  plic_mc_if.slave  bus
);
  logic [NSOURCES-1:0][PRIO_WIDTH-1:0]  prio_q;
  logic [NCONTEXTS-1:0][NSOURCES-1:0]   en_q;
  logic [NCONTEXTS-1:0][PRIO_WIDTH-1:0] thr_q;
  logic [NSOURCES-1:0]                  pend_q, pend_d, ifl_q, ifl_d;
  logic [NCONTEXTS-1:0]                 ext_q, ext_d, cv_q;
  logic [NCONTEXTS-1:0][ID_WIDTH-1:0]   cid_q, cid_d, cmpl_id;
  logic [NCONTEXTS-1:0][NSOURCES-1:0]   elig;
  logic [NCONTEXTS-1:0][PRIO_WIDTH-1:0] best_p;
  logic [NCONTEXTS-1:0][ID_WIDTH-1:0]   best_id;
  logic [NCONTEXTS-1:0]                 found;
  logic [NSOURCES-1:0]                  claim_set, cmpl_clr, lvl_set, edge_set;

  assign cmpl_id = bus.complete_id_i;

  always_comb begin
    elig  = '0;
    ext_d = '0;
    for (int c = 0; c < NCONTEXTS; c++) begin
      for (int k = 0; k < NSOURCES; k++)
        elig[c][k] = pend_q[k] & en_q[c][k] & (prio_q[k] > thr_q[c]);
      ext_d[c] = |elig[c];
    end
  end

  // Contexts arbitrate in index order; sources already taken by a lower context are skipped.
  always_comb begin
    claim_set = '0;
    cid_d     = cid_q;
    best_p    = '0;
    best_id   = '0;
    found     = '0;
    for (int c = 0; c < NCONTEXTS; c++) begin
      for (int k = 0; k < NSOURCES; k++) begin
        if (elig[c][k] && !claim_set[k] && (!found[c] || prio_q[k] > best_p[c])) begin
          found[c]   = 1'b1;
          best_p[c]  = prio_q[k];
          best_id[c] = ID_WIDTH'(k+1);
        end
      end
      if (bus.claim_req_i[c]) begin
        cid_d[c] = best_id[c];
        for (int k = 0; k < NSOURCES; k++)
          if (found[c] && best_id[c] == ID_WIDTH'(k+1)) claim_set[k] = 1'b1;
      end
    end
  end

  always_comb begin
    cmpl_clr = '0;
    for (int c = 0; c < NCONTEXTS; c++)
      for (int k = 0; k < NSOURCES; k++)
        if (bus.complete_i[c] && cmpl_id[c] == ID_WIDTH'(k+1)) cmpl_clr[k] = 1'b1;
  end

`ifdef PLIC_MC_EDGE_TRIG_EN
  logic [NSOURCES-1:0] trig_q, src_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trig_q <= '0;
      src_q  <= '0;
    end else begin
      if (bus.trig_we_i) trig_q <= bus.trig_wdata_i;
      src_q <= bus.src_i;
    end
  end

  // Edge sources latch a new request even while in flight.
  assign lvl_set  = bus.src_i & ~ifl_q & ~trig_q;
  assign edge_set = bus.src_i & ~src_q & trig_q;
`else
  assign lvl_set  = bus.src_i & ~ifl_q;
  assign edge_set = '0;
`endif

  assign pend_d = ((pend_q | lvl_set) & ~claim_set) | edge_set;
  assign ifl_d  = (ifl_q & ~cmpl_clr) | claim_set;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= '0;
      en_q   <= '0;
      thr_q  <= '0;
      pend_q <= '0;
      ifl_q  <= '0;
      ext_q  <= '0;
      cv_q   <= '0;
      cid_q  <= '0;
    end else begin
      if (bus.prio_we_i) prio_q <= bus.prio_wdata_i;
      for (int c = 0; c < NCONTEXTS; c++) begin
        if (bus.en_we_i[c])  en_q[c]  <= bus.en_wdata_i;
        if (bus.thr_we_i[c]) thr_q[c] <= bus.thr_wdata_i;
      end
      pend_q <= pend_d;
      ifl_q  <= ifl_d;
      ext_q  <= ext_d;
      cv_q   <= bus.claim_req_i;
      cid_q  <= cid_d;
    end
  end

  assign bus.ext_irq_o     = ext_q;
  assign bus.claim_valid_o = cv_q;
  assign bus.claim_id_o    = cid_q;
endmodule

// File: tb/tb_plic_mc.sv
// Bench for plic_mc: directed stimulus, cycle model compared every cycle, plus literal checks.
module tb_plic_mc;
  localparam int NS = 16;
  localparam int NC = 2;
  localparam int PW = 3;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  plic_mc_if #(.NSOURCES(NS), .NCONTEXTS(NC), .PRIO_WIDTH(PW), .ID_WIDTH(IW)) bus();
  plic_mc #(.NSOURCES(NS), .NCONTEXTS(NC), .PRIO_WIDTH(PW), .ID_WIDTH(IW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference model state
  int m_prio[NS];
  bit m_en[NC][NS];
  int m_thr[NC];
  bit m_pend[NS], m_ifl[NS], m_trig[NS], m_srcq[NS];
  bit m_ext[NC], m_cv[NC];
  int m_cid[NC];

  function automatic int pick(int c, bit excl[NS]);
    int best = 0;
    int id = 0;
    for (int k = 0; k < NS; k++)
      if (m_pend[k] && m_en[c][k] && m_prio[k] > m_thr[c] && !excl[k] && m_prio[k] > best) begin
        best = m_prio[k];
        id = k + 1;
      end
    return id;
  endfunction

  task automatic model_step();
    bit taken[NS];
    bit clr[NS];
    bit ext_n[NC];
    int id;
    int j;
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) begin
        m_prio[k] = 0; m_pend[k] = 0; m_ifl[k] = 0; m_trig[k] = 0; m_srcq[k] = 0;
        for (int c = 0; c < NC; c++) m_en[c][k] = 0;
      end
      for (int c = 0; c < NC; c++) begin
        m_thr[c] = 0; m_ext[c] = 0; m_cv[c] = 0; m_cid[c] = 0;
      end
      return;
    end
    for (int k = 0; k < NS; k++) begin taken[k] = 0; clr[k] = 0; end
    for (int c = 0; c < NC; c++) ext_n[c] = (pick(c, taken) != 0);
    for (int c = 0; c < NC; c++) begin
      m_cv[c] = bus.claim_req_i[c];
      if (bus.claim_req_i[c]) begin
        id = pick(c, taken);
        m_cid[c] = id;
        if (id != 0) taken[id-1] = 1;
      end
    end
    for (int c = 0; c < NC; c++)
      if (bus.complete_i[c]) begin
        j = int'(bus.complete_id_i[c*IW +: IW]);
        if (j >= 1 && j <= NS && m_ifl[j-1]) clr[j-1] = 1;
      end
    for (int k = 0; k < NS; k++) begin
      if (m_trig[k])
        m_pend[k] = (m_pend[k] && !taken[k]) || (bus.src_i[k] && !m_srcq[k]);
      else
        m_pend[k] = !taken[k] && (m_pend[k] || (bus.src_i[k] && !m_ifl[k]));
      m_ifl[k]  = (m_ifl[k] && !clr[k]) || taken[k];
      m_srcq[k] = bus.src_i[k];
    end
    for (int c = 0; c < NC; c++) m_ext[c] = ext_n[c];
    if (bus.prio_we_i)
      for (int k = 0; k < NS; k++) m_prio[k] = int'(bus.prio_wdata_i[k*PW +: PW]);
    for (int c = 0; c < NC; c++) begin
      if (bus.en_we_i[c]) for (int k = 0; k < NS; k++) m_en[c][k] = bus.en_wdata_i[k];
      if (bus.thr_we_i[c]) m_thr[c] = int'(bus.thr_wdata_i);
    end
`ifdef PLIC_MC_EDGE_TRIG_EN
    if (bus.trig_we_i) for (int k = 0; k < NS; k++) m_trig[k] = bus.trig_wdata_i[k];
`endif
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("ext_irq ctx%0d", c), int'(bus.ext_irq_o[c]), int'(m_ext[c]));
      chk($sformatf("claim_valid ctx%0d", c), int'(bus.claim_valid_o[c]), int'(m_cv[c]));
      chk($sformatf("claim_id ctx%0d", c), int'(bus.claim_id_o[c*IW +: IW]), m_cid[c]);
    end
  end

  // Stimulus helpers
  logic [NS*PW-1:0] prio_img;

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_prio(int id, int p);
    prio_img[(id-1)*PW +: PW] = PW'(p);
    @(negedge clk); bus.prio_wdata_i = prio_img; bus.prio_we_i = 1'b1;
    @(negedge clk); bus.prio_we_i = 1'b0;
  endtask

  task automatic set_en(int c, logic [NS-1:0] mask);
    @(negedge clk); bus.en_wdata_i = mask; bus.en_we_i[c] = 1'b1;
    @(negedge clk); bus.en_we_i = '0;
  endtask

  task automatic set_thr(int c, int t);
    @(negedge clk); bus.thr_wdata_i = PW'(t); bus.thr_we_i[c] = 1'b1;
    @(negedge clk); bus.thr_we_i = '0;
  endtask

  task automatic claim(int c, int exp);
    @(negedge clk); bus.claim_req_i[c] = 1'b1;
    @(negedge clk); bus.claim_req_i = '0;
    chk($sformatf("lit claim_valid ctx%0d", c), int'(bus.claim_valid_o[c]), 1);
    chk($sformatf("lit claim_id ctx%0d", c), int'(bus.claim_id_o[c*IW +: IW]), exp);
  endtask

  task automatic claim2(int exp0, int exp1);
    @(negedge clk); bus.claim_req_i = 2'b11;
    @(negedge clk); bus.claim_req_i = '0;
    chk("lit dual claim_id ctx0", int'(bus.claim_id_o[0 +: IW]), exp0);
    chk("lit dual claim_id ctx1", int'(bus.claim_id_o[IW +: IW]), exp1);
  endtask

  task automatic complete(int c, int id);
    @(negedge clk); bus.complete_i[c] = 1'b1; bus.complete_id_i[c*IW +: IW] = IW'(id);
    @(negedge clk); bus.complete_i = '0;
  endtask

`ifdef PLIC_MC_EDGE_TRIG_EN
  task automatic pulse_src0();
    bus.src_i[0] = 1'b1; tick(1); bus.src_i[0] = 1'b0; tick(1);
  endtask
`endif

  initial begin
    bus.src_i = '0; bus.prio_we_i = 1'b0; bus.prio_wdata_i = '0;
    bus.en_we_i = '0; bus.en_wdata_i = '0; bus.thr_we_i = '0; bus.thr_wdata_i = '0;
    bus.claim_req_i = '0; bus.complete_i = '0; bus.complete_id_i = '0;
`ifdef PLIC_MC_EDGE_TRIG_EN
    bus.trig_we_i = 1'b0; bus.trig_wdata_i = '0;
`endif
    prio_img = '0;
    #1 rst_n = 1'b0;
    tick(2);
    #2 rst_n = 1'b1;
    tick(1);
    chk("lit reset ext_irq", int'(bus.ext_irq_o), 0);
    chk("lit reset claim_valid", int'(bus.claim_valid_o), 0);
    chk("lit reset claim_id", int'(bus.claim_id_o), 0);

    // Basic claim/complete with level masking while in flight
    set_prio(3, 5);
    set_en(0, 16'h0004);
    bus.src_i[2] = 1'b1;
    tick(1); chk("lit src3 ext after 1 edge", int'(bus.ext_irq_o[0]), 0);
    tick(1); chk("lit src3 ext after 2 edges", int'(bus.ext_irq_o[0]), 1);
    claim(0, 3);
    tick(2); chk("lit ext drops after claim", int'(bus.ext_irq_o[0]), 0);
    tick(3); chk("lit masked while in flight", int'(bus.ext_irq_o[0]), 0);
    complete(0, 3);
    tick(2); chk("lit ext reasserts after complete", int'(bus.ext_irq_o[0]), 1);
    claim(0, 3);
    bus.src_i[2] = 1'b0;
    complete(0, 3);

    // Priority ties and higher priority
    set_prio(2, 4);
    set_prio(7, 4);
    set_en(0, 16'h0046);
    bus.src_i[1] = 1'b1; bus.src_i[6] = 1'b1;
    tick(2);
    claim(0, 2);
    complete(0, 2);
    set_prio(7, 6);
    tick(2);
    claim(0, 7);
    bus.src_i[1] = 1'b0; bus.src_i[6] = 1'b0;
    claim(0, 2);
    complete(0, 2);
    complete(0, 7);
    tick(2); chk("lit ctx0 idle", int'(bus.ext_irq_o[0]), 0);
    claim(0, 0);

    // Threshold and priority zero
    set_prio(5, 3);
    set_en(1, 16'h0010);
    set_thr(1, 3);
    bus.src_i[4] = 1'b1;
    tick(3); chk("lit prio==thr blocked", int'(bus.ext_irq_o[1]), 0);
    set_thr(1, 2);
    tick(1); chk("lit prio>thr asserts", int'(bus.ext_irq_o[1]), 1);
    claim(1, 5);
    bus.src_i[4] = 1'b0;
    complete(1, 5);
    set_thr(1, 0);
    set_en(1, 16'h0100);
    bus.src_i[8] = 1'b1;
    tick(3); chk("lit prio0 never asserts", int'(bus.ext_irq_o[1]), 0);
    claim(1, 0);
    bus.src_i[8] = 1'b0;

    // Simultaneous claims
    set_en(0, 16'h0008);
    set_en(1, 16'h0008);
    set_prio(4, 2);
    bus.src_i[3] = 1'b1;
    tick(2);
    claim2(4, 0);
    complete(0, 4);
    set_en(1, 16'h0028);
    set_prio(6, 1);
    bus.src_i[5] = 1'b1;
    tick(3);
    claim2(4, 6);

    // Ignored completions, then reset with ID4 in flight
    complete(1, 0);
    complete(1, 17);
    complete(1, 2);
    tick(2);
    chk("lit ctx0 still masked", int'(bus.ext_irq_o[0]), 0);
    chk("lit ctx1 still masked", int'(bus.ext_irq_o[1]), 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("lit mid reset ext_irq", int'(bus.ext_irq_o), 0);
    chk("lit mid reset claim_valid", int'(bus.claim_valid_o), 0);
    chk("lit mid reset claim_id", int'(bus.claim_id_o), 0);
    prio_img = '0;
    tick(2);
    #2 rst_n = 1'b1;
    set_prio(4, 5);
    set_en(0, 16'h0008);
    tick(1); chk("lit ID4 re-pends after reset", int'(bus.ext_irq_o[0]), 1);
    claim(0, 4);
    bus.src_i[3] = 1'b0; bus.src_i[5] = 1'b0;
    complete(0, 4);

`ifdef PLIC_MC_EDGE_TRIG_EN
    @(negedge clk); bus.trig_wdata_i = 16'h0001; bus.trig_we_i = 1'b1;
    @(negedge clk); bus.trig_we_i = 1'b0;
    set_prio(1, 7);
    set_en(0, 16'h0001);
    pulse_src0();
    chk("lit edge ext", int'(bus.ext_irq_o[0]), 1);
    claim(0, 1);
    pulse_src0();
    complete(0, 1);
    tick(1); chk("lit edge ext after complete", int'(bus.ext_irq_o[0]), 1);
    claim(0, 1);
    complete(0, 1);
    pulse_src0();
    pulse_src0();
    pulse_src0();
    claim(0, 1);
    claim(0, 0);
    complete(0, 1);
`endif

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/plic_mc.md
Name: plic_mc

Overview:
Multi-context platform-level interrupt controller, the parametrised successor of the single-context 8-source PLIC. It gates NSOURCES external lines and arbitrates them independently for NCONTEXTS hart contexts. Each context has its own enable mask and priority threshold, plus a registered claim/complete handshake with ID-matched completion. It sits between peripheral IRQ lines and the per-hart external-interrupt inputs of the core(s).

Parameters:
NSOURCES, 16, number of interrupt sources; source IDs are 1..NSOURCES, ID 0 means "none"
NCONTEXTS, 2, number of target contexts
PRIO_WIDTH, 3, priority/threshold width; priority 0 = source never interrupts
ID_WIDTH, $clog2(NSOURCES+1), width of source ID fields

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
src_i  in  NSOURCES  level interrupt lines; bit k is source ID k+1
prio_we_i  in  1  load all priorities
prio_wdata_i  in  NSOURCES*PRIO_WIDTH  priority of ID k+1 at slice k
en_we_i  in  NCONTEXTS  per-context enable-mask write strobe
en_wdata_i  in  NSOURCES  enable mask data, shared by all strobes
thr_we_i  in  NCONTEXTS  per-context threshold write strobe
thr_wdata_i  in  PRIO_WIDTH  threshold data
claim_req_i  in  NCONTEXTS  claim request pulse per context
complete_i  in  NCONTEXTS  complete pulse per context
complete_id_i  in  NCONTEXTS*ID_WIDTH  ID being completed, slice per context
ext_irq_o  out  NCONTEXTS  external interrupt per context, registered
claim_valid_o  out  NCONTEXTS  one-cycle pulse: claim_id_o slice is valid
claim_id_o  out  NCONTEXTS*ID_WIDTH  claimed ID (0 = nothing claimable)

Behaviour:
- Reset: priorities, enables, thresholds, pending, in_flight, ext_irq_o, claim_valid_o and claim_id_o all 0.
- Gateway, per source:
  - pending[k] is set when src_i[k]=1 and in_flight[k]=0.
  - pending[k] is cleared only by a claim.
  - in_flight[k] is set by a claim and cleared by a matching complete.
  - While in_flight[k]=1, src_i[k] is ignored. No new request is taken until the completion.
- Eligibility for context c: pending & enable[c] & (priority > threshold[c]).
- Selection: highest priority among eligible sources; ties go to the lowest ID. Selection logic is combinational.
- ext_irq_o[c] is registered from "any eligible for c".
  - Source rising (pending set at edge N) -> ext_irq_o high after edge N+1.
  - Any priority/enable/threshold write affects ext_irq_o 2 edges later.
- Claim, claim_req_i[c] sampled high at edge N:
  - At edge N, claim_id_o[c] <= selected ID (or 0) and claim_valid_o[c] <= 1 for one cycle.
  - The selected source's pending is cleared and its in_flight is set.
  - Claim with nothing eligible returns ID 0 and changes no state.
- Simultaneous claims by several contexts for the same source: lowest context index wins. Higher contexts re-arbitrate with that source excluded in the same cycle and may receive their next-best ID or 0.
- claim_id_o holds its value between claims.
- Complete, complete_i[c] with ID j:
  - If 1<=j<=NSOURCES and in_flight[j-1]=1, in_flight clears at that edge.
  - ID 0, out-of-range ID, or a non-in-flight ID is silently ignored.
  - Completion does not check enable of context c.
- Same-cycle complete of j and src high: in_flight clears this edge; pending can set from the next edge.
- Same-cycle claim of j and complete of j: complete applies to the old in_flight, claim sets it; final in_flight=1.
- Register writes take effect at the edge. A write and a claim in the same cycle: the claim uses the pre-write values.
- Reset mid-operation clears all pending and in_flight. Sources still high re-pend one cycle after reset release.

Optional Feature:
Macro PLIC_MC_EDGE_TRIG_EN.
- Defined:
  - Adds ports trig_we_i (1) and trig_wdata_i (NSOURCES), plus a trig register, reset 0 (0=level, 1=rising edge).
  - Edge sources register src_i and set pending on a 0->1 transition, including while in_flight.
  - At most one outstanding edge is latched per source; further edges before the claim are dropped.
- Undefined: all sources are level; the ports and the register do not exist.

Test Plan:
- Src ID3 prio 5, enabled on ctx0, thr 0, src_i[2]=1 -> ext_irq_o[0]=1 two edges later; claim -> claim_id_o[0]=3 with pulse; ext_irq_o[0] drops; src held high stays masked until complete ID3; after complete, ext_irq_o[0] reasserts.
- IDs 2 and 7 both prio 4 pending -> claim returns 2; ID 7 prio 6 -> claim returns 7.
- Threshold: ID5 prio 3, ctx1 thr 3 -> no ext_irq_o[1]; thr set to 2 -> ext_irq_o[1]=1; prio 0 source never asserts.
- Both contexts enable ID4 (only eligible source) and claim in the same cycle -> ctx0 gets 4, ctx1 gets 0; with ID6 also eligible for ctx1, ctx1 gets 6.
- Complete with ID 0, ID 17 and a non-in-flight ID -> no state change; reset asserted with ID4 in flight -> all outputs 0; ID4 re-pends one cycle after release.
- (EDGE_TRIG_EN) ID1 edge mode: pulse, claim, second pulse before complete -> after complete, ext_irq_o reasserts and a claim returns 1; three pulses before the claim yield exactly one claim.
